// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer: drives every CPU datapath strobe from its state and the IR.
// Latency: strobes are combinational from state/IR; NOP/MOV take 3 cycles, LDI/ALU/JMP/JZ/JC take 4.
// Backpressure: none; the sequencer advances every clock until HALT, which only reset leaves.
module control_unit #(
  parameter int IW              = 8,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] ir_in,
  input  logic          flag_zero,
  input  logic          flag_carry,
  output logic          c_pco,
  output logic          c_mai,
  output logic          c_mro,
  output logic          c_ien,
  output logic          c_pcinc,
  output logic          c_pcld,
  output logic          c_rin,
  output logic          c_rou,
  output logic          c_aen,
  output logic          c_aou,
  output logic [2:0]    sel_in,
  output logic [2:0]    sel_out,
  output logic [2:0]    alu_mode,
  output logic          halted,
  output logic          illegal,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_E0   = 3'd3,
    S_E1   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ALU = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] opcode;
  logic [2:0] operand;
  logic       unused_ir;

  assign opcode    = ir_in[IW-1:IW-4];
  assign operand   = ir_in[2:0];
  // Bits between the operand and the opcode carry no meaning for this ISA.
  assign unused_ir = ^ir_in[IW-5:3];
  assign state     = cur_state;

  // State register; reset aborts any instruction in flight and parks in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state and strobe decode; everything defaults to idle so unused selects stay 0.
  always_comb begin
    nxt_state = cur_state;
    c_pco     = 1'b0;
    c_mai     = 1'b0;
    c_mro     = 1'b0;
    c_ien     = 1'b0;
    c_pcinc   = 1'b0;
    c_pcld    = 1'b0;
    c_rin     = 1'b0;
    c_rou     = 1'b0;
    c_aen     = 1'b0;
    c_aou     = 1'b0;
    sel_in    = 3'd0;
    sel_out   = 3'd0;
    alu_mode  = 3'd0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (cur_state)
      S_IDLE: nxt_state = S_F0;
      S_F0: begin
        c_pco     = 1'b1;
        c_mai     = 1'b1;
        nxt_state = S_F1;
      end
      S_F1: begin
        c_mro     = 1'b1;
        c_ien     = 1'b1;
        c_pcinc   = 1'b1;
        nxt_state = S_E0;
      end
      S_E0: begin
        nxt_state = S_F0;
        case (opcode)
          OP_NOP: ;
          OP_LDI, OP_JMP, OP_JZ, OP_JC: begin
            // Point MAR at the operand byte that follows the opcode.
            c_pco     = 1'b1;
            c_mai     = 1'b1;
            nxt_state = S_E1;
          end
          OP_MOV: begin
            c_rou   = 1'b1;
            sel_out = operand;
            c_rin   = 1'b1;
          end
          OP_ALU: begin
            c_aen     = 1'b1;
            alu_mode  = operand;
            nxt_state = S_E1;
          end
          OP_HLT: nxt_state = S_HALT;
          default: begin
            illegal   = 1'b1;
            nxt_state = HALT_ON_ILLEGAL ? S_HALT : S_F0;
          end
        endcase
      end
      S_E1: begin
        nxt_state = S_F0;
        case (opcode)
          OP_LDI: begin
            c_mro   = 1'b1;
            c_rin   = 1'b1;
            sel_in  = operand;
            c_pcinc = 1'b1;
          end
          OP_ALU: begin
            c_aou    = 1'b1;
            c_rin    = 1'b1;
            alu_mode = operand;
          end
          OP_JMP: begin
            c_mro  = 1'b1;
            c_pcld = 1'b1;
          end
          OP_JZ, OP_JC: begin
            // Not taken still has to step the PC past the target byte.
            if ((opcode == OP_JZ) ? flag_zero : flag_carry) begin
              c_mro  = 1'b1;
              c_pcld = 1'b1;
            end else begin
              c_pcinc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected strobe sequences from the ISA table.
// Latency: compares every cycle of every instruction, plus the state landed on afterwards.
// Backpressure: not applicable; stimulus advances one clock at a time.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ir = 8'h00;
  logic       fz = 1'b0;
  logic       fc = 1'b0;

  logic c_pco, c_mai, c_mro, c_ien, c_pcinc, c_pcld, c_rin, c_rou, c_aen, c_aou;
  logic [2:0] sel_in, sel_out, alu_mode, state;
  logic halted, illegal;

  logic h_pco, h_mai, h_mro, h_ien, h_pcinc, h_pcld, h_rin, h_rou, h_aen, h_aou;
  logic [2:0] h_sel_in, h_sel_out, h_alu_mode, h_state;
  logic h_halted, h_illegal;

  typedef struct packed {
    logic pco, mai, mro, ien, pcinc, pcld, rin, rou, aen, aou;
    logic [2:0] sel_in, sel_out, alu_mode;
    logic halted, illegal;
    logic [2:0] state;
  } obs_t;

  obs_t obs;
  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  assign obs = {c_pco, c_mai, c_mro, c_ien, c_pcinc, c_pcld, c_rin, c_rou, c_aen, c_aou,
                sel_in, sel_out, alu_mode, halted, illegal, state};

  always #5 clk = ~clk;

  control_unit #(.IW(8), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .ir_in(ir), .flag_zero(fz), .flag_carry(fc),
    .c_pco(c_pco), .c_mai(c_mai), .c_mro(c_mro), .c_ien(c_ien), .c_pcinc(c_pcinc),
    .c_pcld(c_pcld), .c_rin(c_rin), .c_rou(c_rou), .c_aen(c_aen), .c_aou(c_aou),
    .sel_in(sel_in), .sel_out(sel_out), .alu_mode(alu_mode), .halted(halted),
    .illegal(illegal), .state(state)
  );

  control_unit #(.IW(8), .HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .reset(reset), .ir_in(ir), .flag_zero(fz), .flag_carry(fc),
    .c_pco(h_pco), .c_mai(h_mai), .c_mro(h_mro), .c_ien(h_ien), .c_pcinc(h_pcinc),
    .c_pcld(h_pcld), .c_rin(h_rin), .c_rou(h_rou), .c_aen(h_aen), .c_aou(h_aou),
    .sel_in(h_sel_in), .sel_out(h_sel_out), .alu_mode(h_alu_mode), .halted(h_halted),
    .illegal(h_illegal), .state(h_state)
  );

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  // ISA reference: the full cycle-by-cycle strobe picture of one instruction from fetch onward.
  function automatic void push_instr(input logic [7:0] i, input logic z, input logic c);
    logic [3:0] op;
    logic [2:0] r;
    obs_t e;
    op = i[7:4];
    r  = i[2:0];
    e = blank(3'd1); e.pco = 1'b1; e.mai = 1'b1; exp_q.push_back(e);
    e = blank(3'd2); e.mro = 1'b1; e.ien = 1'b1; e.pcinc = 1'b1; exp_q.push_back(e);
    e = blank(3'd3);
    if (op inside {4'h1, 4'h4, 4'h5, 4'h6}) begin e.pco = 1'b1; e.mai = 1'b1; end
    else if (op == 4'h2) begin e.rou = 1'b1; e.sel_out = r; e.rin = 1'b1; end
    else if (op == 4'h3) begin e.aen = 1'b1; e.alu_mode = r; end
    else if (!(op inside {4'h0, 4'hF})) e.illegal = 1'b1;
    exp_q.push_back(e);
    e = blank(3'd4);
    case (op)
      4'h1: begin e.mro = 1'b1; e.rin = 1'b1; e.sel_in = r; e.pcinc = 1'b1; exp_q.push_back(e); end
      4'h3: begin e.aou = 1'b1; e.rin = 1'b1; e.alu_mode = r; exp_q.push_back(e); end
      4'h4: begin e.mro = 1'b1; e.pcld = 1'b1; exp_q.push_back(e); end
      4'h5, 4'h6: begin
        if ((op == 4'h5) ? z : c) begin e.mro = 1'b1; e.pcld = 1'b1; end
        else e.pcinc = 1'b1;
        exp_q.push_back(e);
      end
      default: ;
    endcase
  endfunction

  // Runs one instruction starting in F0 and checks every cycle plus the landing state.
  task automatic run_instr(input logic [7:0] i, input logic z, input logic c, input string name);
    obs_t e;
    int   n;
    logic [2:0] land;
    ir = i; fz = z; fc = c;
    exp_q.delete();
    push_instr(i, z, c);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s ir=%h cyc%0d: got %h, expected %h", name, i, k, obs, e);
      end
      tests++;
      if ($countones({c_pco, c_mro, c_rou, c_aou}) > 1 || (c_pcinc && c_pcld)) begin
        fails++;
        $display("FAIL %s invariant cyc%0d: drivers=%b pcinc=%b pcld=%b, expected <=1 driver and not both",
                 name, k, {c_pco, c_mro, c_rou, c_aou}, c_pcinc, c_pcld);
      end
      @(posedge clk); #1;
    end
    land = (i[7:4] == 4'hF) ? 3'd7 : 3'd1;
    tests++;
    if (state !== land) begin
      fails++;
      $display("FAIL %s ir=%h landing: got state %0d, expected %0d", name, i, state, land);
    end
  endtask

  // Holds reset for three cycles, releases it, and leaves both DUTs just after entering F0.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_async: got %h, expected 0", obs); end
    for (int k = 0; k < 3; k++) begin
      ir = 8'($urandom); fz = 1'($urandom); fc = 1'($urandom);
      @(negedge clk);
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL reset_hold cyc%0d: got %h, expected 0", k, obs); end
    end
    reset = 1'b0;
    #1;
    tests++;
    if (state !== 3'd0) begin fails++; $display("FAIL reset_release: got state %0d, expected 0", state); end
    @(posedge clk); #1;
    run_instr(8'h00, 1'b0, 1'b0, "reset_seq");
  endtask

  task automatic test_ldi();
    run_instr(8'h13, 1'b0, 1'b0, "ldi_r3");
    run_instr(8'h16, 1'b1, 1'b1, "ldi_r6");
  endtask

  task automatic test_alu_mov();
    run_instr(8'h35, 1'b0, 1'b0, "alu_m5");
    run_instr(8'h27, 1'b0, 1'b0, "mov_r7");
  endtask

  task automatic test_branch();
    run_instr(8'h50, 1'b1, 1'b0, "jz_taken");
    run_instr(8'h50, 1'b0, 1'b1, "jz_not");
    run_instr(8'h60, 1'b0, 1'b1, "jc_taken");
    run_instr(8'h60, 1'b1, 1'b0, "jc_not");
    run_instr(8'h40, 1'b0, 1'b0, "jmp");
  endtask

  task automatic test_halt();
    obs_t e;
    run_instr(8'hF0, 1'b0, 1'b0, "hlt");
    e = blank(3'd7);
    e.halted = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ir = 8'($urandom); fz = 1'($urandom); fc = 1'($urandom);
      @(negedge clk);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL halt_hold cyc%0d: got %h, expected %h", k, obs, e); end
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL halt_async_reset: got %h, expected 0", obs); end
    do_reset();
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(8'h80, 1'b0, 1'b0, "illegal_nop");
    tests++;
    if (h_state !== 3'd7 || h_halted !== 1'b1 || h_illegal !== 1'b0) begin
      fails++;
      $display("FAIL illegal_halt: got state %0d halted %b illegal %b, expected 7 1 0",
               h_state, h_halted, h_illegal);
    end
    run_instr(8'h00, 1'b0, 1'b0, "after_illegal");
  endtask

  task automatic test_reset_mid();
    ir = 8'h13;
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (state !== 3'd4 || c_rin !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre: got state %0d rin %b, expected 4 1", state, c_rin);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL mid_reset: got %h, expected 0", obs); end
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int k = 0; k < 80; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom)}, 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu_mov();
    test_branch();
    test_halt();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
